dp_shift_alu: RTL

//   Execute stage of the data-processing path. Consumes the latched operand registers
//   A (Rn), B (Rm) and C (Rs) and produces F_New and NZCV_New for the result/flag latch.

---
 rtl/dp_pkg.sv | 44 ++++
 rtl/dp_alu.sv | 64 ++++++
 rtl/dp_shift_alu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing execute stage: ARM opcodes,
// shifter encodings, FSM states and opcode classification helpers.
package dp_pkg;

  localparam int DP_W = 32;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ALU   = 2'd2
  } state_t;

  function automatic logic is_logical(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_TST) || (op == OP_TEQ) ||
           (op == OP_ORR) || (op == OP_MOV) || (op == OP_BIC) || (op == OP_MVN);
  endfunction

  function automatic logic is_test(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ARM data-processing ALU: 16 opcodes over a 33-bit adder,
// producing the result, the new NZCV and the register write enable.
module dp_alu
  import dp_pkg::*;
(
  input  logic [3:0]      opcode,
  input  logic [DP_W-1:0] a,
  input  logic [DP_W-1:0] b,
  input  logic            cin,
  input  logic            cs,
  input  logic [3:0]      nzcv_in,
  output logic [DP_W-1:0] f,
  output logic [3:0]      nzcv,
  output logic            wr
);

  logic [DP_W-1:0] w_x;
  logic [DP_W-1:0] w_y;
  logic            w_ci;
  logic [DP_W:0]   w_sum;
  logic            w_logic;
  logic            w_c;
  logic            w_v;
  logic            w_unused_nzcv;

  assign w_unused_nzcv = &{1'b0, nzcv_in[3:1]};

  // Subtractions are folded into the adder as x + ~y + carry, so the adder
  // carry-out is directly the ARM "not borrow" flag.
  always_comb begin
    w_x  = a;
    w_y  = b;
    w_ci = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin w_y = ~b; w_ci = 1'b1; end
      OP_RSB:         begin w_x = b; w_y = ~a; w_ci = 1'b1; end
      OP_ADC:         begin w_ci = cin; end
      OP_SBC:         begin w_y = ~b; w_ci = cin; end
      OP_RSC:         begin w_x = b; w_y = ~a; w_ci = cin; end
      default:        begin end
    endcase
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{DP_W{1'b0}}, w_ci};
  end

  always_comb begin
    w_logic = is_logical(opcode);
    f       = w_sum[DP_W-1:0];
    case (opcode)
      OP_AND, OP_TST: f = a & b;
      OP_EOR, OP_TEQ: f = a ^ b;
      OP_ORR:         f = a | b;
      OP_MOV:         f = b;
      OP_BIC:         f = a & ~b;
      OP_MVN:         f = ~b;
      default:        f = w_sum[DP_W-1:0];
    endcase
    w_c  = w_logic ? cs : w_sum[DP_W];
    w_v  = w_logic ? nzcv_in[0]
                   : ((w_x[DP_W-1] == w_y[DP_W-1]) && (w_sum[DP_W-1] != w_x[DP_W-1]));
    nzcv = {f[DP_W-1], (f == '0), w_c, w_v};
    wr   = ~is_test(opcode);
  end

endmodule

// File: rtl/dp_shift_alu.sv
// Execute stage: iterative 1-bit-per-cycle ARM barrel shifter on B feeding
// the DP ALU, sequenced by an IDLE -> SHIFT -> ALU FSM with start/busy/done.
module dp_shift_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [3:0]        opcode,
  input  logic              S,
  input  logic [1:0]        shift_type,
  input  logic [4:0]        shift_imm,
  input  logic              shift_by_reg,
  input  logic [3:0]        NZCV,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] F_New,
  output logic [3:0]        NZCV_New,
  output logic              write_en,
  output state_t            dbg_state
);

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_sh;
  logic [5:0]        r_cnt;
  logic              r_cs;
  logic              r_rrx;
  logic [1:0]        r_type;
  logic [3:0]        r_op;
  logic              r_s;
  logic [3:0]        r_nzcv;

  logic [AMT_W-1:0]  w_amt;
  logic [AMT_W-1:0]  w_amt_eff;
  logic [5:0]        w_n;
  logic              w_rrx;
  logic              w_cs0;
  logic              w_unused_c;
  logic [DATA_W-1:0] w_f;
  logic [3:0]        w_nzcv;
  logic              w_wr;

  assign w_unused_c = &{1'b0, C[DATA_W-1:AMT_W]};
  assign dbg_state  = r_state;

  // LSR/ASR immediate #0 encodes a shift of 32; ROR immediate #0 is RRX.
  always_comb begin
    w_amt     = shift_by_reg ? C[AMT_W-1:0] : AMT_W'(shift_imm);
    w_amt_eff = (!shift_by_reg && shift_imm == 5'd0 &&
                 (shift_type == SH_LSR || shift_type == SH_ASR)) ? AMT_W'(32) : w_amt;
    w_rrx     = (shift_type == SH_ROR) && !shift_by_reg && (shift_imm == 5'd0);
    w_cs0     = NZCV[1];
    case (shift_type)
      SH_LSL, SH_LSR: w_n = (w_amt_eff > AMT_W'(33)) ? 6'd33 : w_amt_eff[5:0];
      SH_ASR:         w_n = (w_amt_eff > AMT_W'(32)) ? 6'd32 : w_amt_eff[5:0];
      default: begin
        w_n = w_rrx ? 6'd1 : {1'b0, w_amt[4:0]};
        if (shift_by_reg && w_amt[4:0] == 5'd0 && w_amt != '0) w_cs0 = B[DATA_W-1];
      end
    endcase
  end

  dp_alu u_alu (
    .opcode  (r_op),
    .a       (r_a),
    .b       (r_sh),
    .cin     (r_nzcv[1]),
    .cs      (r_cs),
    .nzcv_in (r_nzcv),
    .f       (w_f),
    .nzcv    (w_nzcv),
    .wr      (w_wr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_cs     <= 1'b0;
      r_rrx    <= 1'b0;
      r_type   <= SH_LSL;
      r_op     <= OP_AND;
      r_s      <= 1'b0;
      r_nzcv   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      F_New    <= '0;
      NZCV_New <= '0;
      write_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_sh    <= B;
            r_cnt   <= w_n;
            r_cs    <= w_cs0;
            r_rrx   <= w_rrx;
            r_type  <= shift_type;
            r_op    <= opcode;
            r_s     <= S;
            r_nzcv  <= NZCV;
            busy    <= 1'b1;
            r_state <= (w_n == 6'd0) ? ALU : SHIFT;
          end
        end
        SHIFT: begin
          // The last bit shifted out becomes the shifter carry.
          case (r_type)
            SH_LSL: begin r_cs <= r_sh[DATA_W-1]; r_sh <= {r_sh[DATA_W-2:0], 1'b0}; end
            SH_LSR: begin r_cs <= r_sh[0]; r_sh <= {1'b0, r_sh[DATA_W-1:1]}; end
            SH_ASR: begin r_cs <= r_sh[0]; r_sh <= {r_sh[DATA_W-1], r_sh[DATA_W-1:1]}; end
            default: begin
              r_cs <= r_sh[0];
              r_sh <= {(r_rrx ? r_nzcv[1] : r_sh[0]), r_sh[DATA_W-1:1]};
            end
          endcase
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= ALU;
        end
        ALU: begin
          F_New    <= w_f;
          NZCV_New <= r_s ? w_nzcv : r_nzcv;
          write_en <= w_wr;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
